des_spi_frontend: RTL
=====================

# des_spi_frontend

SPI slave front end for the fixed-key DES scan-chain core. It sits directly upstream of the DES core. It deserialises host commands and 64-bit text from an SPI link, loads the core's `starttext`, and pulses `start`. It also serialises `finishtext` and status back to the host. An optional path bridges SPI bits onto the core's scan chain.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_sclk`, `spi_cs_n` and `spi_mosi` (minimum 2).

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `rst`  in  1  reset, synchronous, active-high.
- `spi_sclk`  in  1  SPI clock (mode 0), asynchronous to `clk`.
- `spi_cs_n`  in  1  chip select, active low, asynchronous.
- `spi_mosi`  in  1  host-to-block data, MSB first.
- `spi_miso`  out  1  block-to-host data, MSB first.
- `starttext`  out  64  text to the core.
- `encrypt_ndecrypt`  out  1  1 selects encrypt, 0 selects decrypt.
- `start`  out  1  one-`clk` start pulse to the core.
- `busy`  in  1  core busy.
- `finishtext`  in  64  core result.
- `scan_enable`  out  1  scan shift enable (macro only; tied 0 otherwise).
- `scan_in`  out  1  scan data into the chain.
- `scan_out`  in  1  scan data from the chain.

## Operation
- All SPI inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronised signals.
- `spi_sclk` rising edge: sample MOSI. `spi_sclk` falling edge: update MISO.
- States: IDLE, CMD, WR_DATA, RD_DATA, SCAN, DISCARD.
- IDLE -> CMD on synchronised `spi_cs_n` falling edge. The bit counter clears.
- CMD: shift in 8 bits. On the 8th rising edge, decode the opcode:
  - 0x01 ENC -> WR_DATA with encrypt flag = 1.
  - 0x02 DEC -> WR_DATA with encrypt flag = 0.
  - 0x03 READ -> RD_DATA with a 64-bit snapshot of `finishtext`; clear `done`.
  - 0x04 STATUS -> RD_DATA with the 8-bit word {5'b0, err, done, busy} in the MSBs.
  - 0x10 SCAN -> SCAN (macro only).
  - Any other opcode -> DISCARD.
- WR_DATA: shift in 64 bits. On the 64th rising edge:
  - If `busy` = 0: load `starttext` and `encrypt_ndecrypt`, pulse `start`, then go to DISCARD.
  - If `busy` = 1: leave the outputs unchanged, set sticky `err`, then go to DISCARD.
- RD_DATA: shift the snapshot out on MISO. After the data is exhausted, MISO = 0.
- DISCARD: ignore MOSI; MISO = 0.
- `spi_cs_n` rising edge in any state -> IDLE. Partial data is discarded, and no `start` is issued for an incomplete frame.
- `done` sets on the `busy` falling edge and clears on READ opcode decode.
- `err` clears only on reset.
- If `busy` falls in the same cycle as READ decode, `done` ends up set (set wins).

## Timing
- SCLK frequency must be at most `clk`/8.
- `start` is high for exactly 1 `clk`, in the cycle after the synchronised 64th rising edge is detected.
- `starttext` and `encrypt_ndecrypt` update in that same cycle and hold until the next accepted write.
- The READ/STATUS snapshot is captured in the decode cycle. Its first bit drives MISO from the next falling `spi_sclk` edge.
- During CMD, MISO = 0.
- Reset values:
  - `spi_miso`, `start`, `encrypt_ndecrypt`, `scan_enable`, `scan_in`: 0.
  - `starttext`: 64'h0.
  - State: IDLE.
  - Bit counter, `done`, `err`: 0.
- `rst` mid-frame aborts immediately. The host must deassert and reassert `spi_cs_n` before the next command.

## Configuration
- Macro `DES_SPI_SCAN_BRIDGE_EN`, when defined:
  - Opcode 0x10 enters SCAN.
  - Each synchronised rising SCLK edge drives `scan_in` = MOSI bit and asserts `scan_enable` for exactly 1 `clk`.
  - MISO presents the `scan_out` value registered just before each shift.
  - SCAN continues until `spi_cs_n` rises.
- Without the macro: 0x10 is treated as an unknown opcode (DISCARD), `scan_enable` and `scan_in` are constant 0, and `scan_out` is unused.

## Structure
- Package `des_spi_pkg` holds:
  - Opcode localparams: OP_ENC, OP_DEC, OP_READ, OP_STATUS, OP_SCAN.
  - State enum.
  - Status bit indices.
  - Command width (8) and text width (64).
- One sub-module, `spi_sync_edge`: `SYNC_STAGES` synchroniser plus registered rise/fall pulses. It is instantiated for `spi_sclk` and `spi_cs_n`. `spi_mosi` uses the synchroniser only.

## Test plan
- ENC frame 0x01 + 64'h0123456789ABCDEF with `busy` = 0 -> single-cycle `start`, `starttext` = 0123456789ABCDEF, `encrypt_ndecrypt` = 1.
- DEC frame while `busy` = 1 -> no `start`, `starttext` unchanged; a following STATUS read returns 8'b0000_0101 while `busy` is still 1.
- Model `busy` falling, then READ with `finishtext` = 64'h85E813540F0AB405 -> MISO shifts 85E813540F0AB405; a following STATUS read shows `done` = 0.
- `spi_cs_n` raised after 40 data bits of an ENC frame -> no `start`; a next full frame is accepted normally.
- Unknown opcode 0x7F -> MISO = 0 for the whole frame and no outputs change; the same happens for 0x10 when the macro is off.
- With `DES_SPI_SCAN_BRIDGE_EN` defined, SCAN with 8 MOSI bits 0xA5 -> 8 `scan_enable` pulses with `scan_in` sequence 1,0,1,0,0,1,0,1, and MISO echoes the modelled `scan_out` stream.

Source files
------------

// File: rtl/des_spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : des_spi_pkg                                           |
// | Purpose  : Shared opcodes, FSM state encoding, status bit        |
// |            positions and field widths for the DES SPI front end. |
// | Ports    : none (package)                                        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package des_spi_pkg;

  localparam int CMD_W  = 8;
  localparam int TEXT_W = 64;

  localparam logic [7:0] OP_ENC    = 8'h01;
  localparam logic [7:0] OP_DEC    = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] OP_SCAN   = 8'h10;

  // Bit positions inside the 8-bit STATUS word {5'b0, err, done, busy}
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_DATA = 3'd3,
    S_SCAN    = 3'd4,
    S_DISCARD = 3'd5
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_sync_edge                                         |
// | Purpose  : Multi-flop synchroniser for an asynchronous SPI pin,  |
// |            followed by registered single-cycle rise/fall pulses. |
// | Ports    : clk, rst       - system clock / sync active-high rst  |
// |            async_in       - asynchronous input pin               |
// |            rise, fall     - one-clk edge pulses (registered)     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= w_sync;
      rise   <= w_sync & ~r_prev;
      fall   <= ~w_sync & r_prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/des_spi_frontend.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : des_spi_frontend                                      |
// | Purpose  : SPI (mode 0) slave front end for the DES core. Takes  |
// |            ENC/DEC/READ/STATUS commands, loads starttext, pulses |
// |            start, returns finishtext and status on MISO.         |
// | Macro    : DES_SPI_SCAN_BRIDGE_EN - adds SCAN opcode 0x10 that   |
// |            bridges SPI bits onto the core scan chain.            |
// | Ports    : clk, rst                  - clock, sync active-high   |
// |            spi_sclk/cs_n/mosi/miso   - SPI link                  |
// |            starttext, encrypt_ndecrypt, start - to the core      |
// |            busy, finishtext          - from the core             |
// |            scan_enable, scan_in, scan_out - scan chain bridge    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module des_spi_frontend
  import des_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [63:0] starttext,
  output logic        encrypt_ndecrypt,
  output logic        start,
  input  logic        busy,
  input  logic [63:0] finishtext,
  output logic        scan_enable,
  output logic        scan_in,
  input  logic        scan_out
);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .async_in(spi_sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  // cs_n syncs from 0: if the host is still mid-frame after reset no falling
  // edge is seen, so it must deassert and reassert before being heard.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst(rst), .async_in(spi_cs_n), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_state_t          r_state, w_next_state;
  logic [6:0]          r_bit_cnt;
  logic [TEXT_W-2:0]   r_shift;
  logic [TEXT_W-1:0]   r_tx;
  logic                r_miso, r_busy_d, r_done, r_err, r_enc_flag;

  logic                w_decode, w_wr_last, w_busy_fall;
  logic [CMD_W-1:0]    w_cmd;
  logic [TEXT_W-1:0]   w_wr_text;
  logic [7:0]          w_status;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_next_state = r_state;
    if (w_cs_rise) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_cs_fall) w_next_state = S_CMD;
        S_CMD: begin
          if (w_decode) begin
            case (w_cmd)
              OP_ENC, OP_DEC:     w_next_state = S_WR_DATA;
              OP_READ, OP_STATUS: w_next_state = S_RD_DATA;
`ifdef DES_SPI_SCAN_BRIDGE_EN
              OP_SCAN:            w_next_state = S_SCAN;
`endif
              default:            w_next_state = S_DISCARD;
            endcase
          end
        end
        S_WR_DATA: if (w_wr_last) w_next_state = S_DISCARD;
        default:   w_next_state = r_state;
      endcase
    end
  end

  // ---------------- decode / output comb ----------------
  always_comb begin
    w_cmd       = {r_shift[CMD_W-2:0], w_mosi};
    w_wr_text   = {r_shift, w_mosi};
    w_decode    = (r_state == S_CMD) && w_sclk_rise && (r_bit_cnt == 7'(CMD_W - 1));
    w_wr_last   = (r_state == S_WR_DATA) && w_sclk_rise && (r_bit_cnt == 7'(TEXT_W - 1));
    w_busy_fall = r_busy_d & ~busy;
    w_status            = 8'h00;
    w_status[STAT_BUSY] = busy;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_ERR]  = r_err;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mosi_sync      <= '0;
      r_bit_cnt        <= 7'd0;
      r_shift          <= '0;
      r_tx             <= '0;
      r_miso           <= 1'b0;
      r_busy_d         <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_enc_flag       <= 1'b0;
      starttext        <= '0;
      encrypt_ndecrypt <= 1'b0;
      start            <= 1'b0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_busy_d    <= busy;
      start       <= 1'b0;

      // set has priority over the READ clear
      if (w_busy_fall)                    r_done <= 1'b1;
      else if (w_decode && w_cmd == OP_READ) r_done <= 1'b0;

      if (r_state == S_IDLE) r_bit_cnt <= 7'd0;

      if (w_sclk_rise && (r_state == S_CMD || r_state == S_WR_DATA)) begin
        r_shift   <= {r_shift[TEXT_W-3:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 7'd1;
      end

      if (w_decode) begin
        r_bit_cnt <= 7'd0;
        if (w_cmd == OP_ENC) r_enc_flag <= 1'b1;
        if (w_cmd == OP_DEC) r_enc_flag <= 1'b0;
        if (w_cmd == OP_READ)   r_tx <= finishtext;
        if (w_cmd == OP_STATUS) r_tx <= {w_status, 56'h0};
      end

      if (w_wr_last) begin
        r_bit_cnt <= 7'd0;
        if (!busy) begin
          starttext        <= w_wr_text;
          encrypt_ndecrypt <= r_enc_flag;
          start            <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end

      // Zeros shift in behind the snapshot so MISO idles low once exhausted.
      case (r_state)
        S_RD_DATA: if (w_sclk_fall) begin
          r_miso <= r_tx[TEXT_W-1];
          r_tx   <= {r_tx[TEXT_W-2:0], 1'b0};
        end
`ifdef DES_SPI_SCAN_BRIDGE_EN
        S_SCAN:    if (w_sclk_fall) r_miso <= scan_out;
`endif
        default:   r_miso <= 1'b0;
      endcase
    end
  end

  assign spi_miso = r_miso;

`ifdef DES_SPI_SCAN_BRIDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
    end else begin
      scan_enable <= 1'b0;
      if (r_state == S_SCAN && w_sclk_rise) begin
        scan_enable <= 1'b1;
        scan_in     <= w_mosi;
      end
    end
  end
`else
  logic w_scan_out_unused;
  assign w_scan_out_unused = scan_out;
  assign scan_enable       = 1'b0;
  assign scan_in           = 1'b0;
`endif

endmodule
`default_nettype wire
